// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared SRAM constants and read-serializer state type
package sram_pkg;

    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    typedef enum logic [1:0] {
        SRD_IDLE   = 2'd0,
        SRD_SHIFT  = 2'd1,
        SRD_PARITY = 2'd2
    } srd_state_t;

endpackage

// File: rtl/sram_rd_serializer.sv
// rtl/sram_rd_serializer.sv - SRAM read-back PISO with first/last framing (optional SRD_PARITY_EN)
module sram_rd_serializer
    import sram_pkg::*;
#(
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [COLS-1:0] par_in,
    input  logic            par_valid,
    output logic            par_ready,
    input  logic            flush,
    output logic            serial_out,
    output logic            ser_valid,
    input  logic            ser_ready,
    output logic            ser_first,
    output logic            ser_last,
    output logic            busy
);

    localparam int CNT_W = $clog2(COLS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COLS - 1);

    srd_state_t      state;
    logic [COLS-1:0] shift_reg;
    logic [CNT_W-1:0] cnt;
    logic            xfer;
    logic            frame_end;
    logic            accept;

`ifdef SRD_PARITY_EN
    logic            parity_bit;
`endif

    assign xfer   = ser_valid && ser_ready;
    assign accept = par_valid && par_ready;

    // Handshake and framing flags decoded from the registered state
    always_comb begin
        ser_valid  = (state != SRD_IDLE);
        busy       = (state != SRD_IDLE);
        ser_first  = (state == SRD_SHIFT) && (cnt == '0);
`ifdef SRD_PARITY_EN
        frame_end  = (state == SRD_PARITY);
        ser_last   = (state == SRD_PARITY);
        serial_out = (state == SRD_PARITY) ? parity_bit : shift_reg[0];
`else
        frame_end  = (state == SRD_SHIFT) && (cnt == CNT_LAST);
        ser_last   = frame_end;
        serial_out = shift_reg[0];
`endif
        // A new word may enter while idle, or on the edge that retires the final bit
        par_ready  = !flush && ((state == SRD_IDLE) || (frame_end && ser_ready));
    end

    // Frame FSM, bit counter and shift register; flush wins over every transfer
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= SRD_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
`ifdef SRD_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (flush) begin
            state     <= SRD_IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (accept) begin
            state     <= SRD_SHIFT;
            shift_reg <= par_in;
            cnt       <= '0;
`ifdef SRD_PARITY_EN
            parity_bit <= ^par_in;
`endif
        end else if (xfer) begin
            case (state)
                SRD_SHIFT: begin
                    shift_reg <= shift_reg >> 1;
                    if (cnt == CNT_LAST) begin
`ifdef SRD_PARITY_EN
                        state <= SRD_PARITY;
                        cnt   <= cnt + CNT_W'(1);
`else
                        state <= SRD_IDLE;
                        cnt   <= '0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SRD_PARITY: begin
                    state <= SRD_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state <= SRD_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_rd_serializer.sv
// tb/tb_sram_rd_serializer.sv - randomized and directed bench for sram_rd_serializer
module tb_sram_rd_serializer;

    localparam int COLS = 8;
`ifdef SRD_PARITY_EN
    localparam int FLEN = COLS + 1;
`else
    localparam int FLEN = COLS;
`endif

    logic            clk = 1'b0;
    logic            arst_n = 1'b0;
    logic [COLS-1:0] par_in = '0;
    logic            par_valid = 1'b0;
    logic            par_ready;
    logic            flush = 1'b0;
    logic            serial_out;
    logic            ser_valid;
    logic            ser_ready = 1'b0;
    logic            ser_first;
    logic            ser_last;
    logic            busy;

    int checks = 0;
    int failures = 0;

    // Reference: bits of the frame still to be delivered, front = bit on the wire
    bit q[$];

    logic s_out, s_valid, s_first, s_last, s_pr, s_busy;

    sram_rd_serializer #(.COLS(COLS)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .par_in    (par_in),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .flush     (flush),
        .serial_out(serial_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare DUT to the model mid-cycle, then advance the model
    task automatic step(input bit pv, input logic [COLS-1:0] pin, input bit sr, input bit fl);
        bit exp_valid;
        bit exp_pr;
        par_valid = pv;
        par_in    = pin;
        ser_ready = sr;
        flush     = fl;
        @(negedge clk);
        exp_valid = (q.size() > 0);
        exp_pr    = !fl && ((q.size() == 0) || (q.size() == 1 && sr));
        s_out = serial_out; s_valid = ser_valid; s_first = ser_first;
        s_last = ser_last; s_pr = par_ready; s_busy = busy;
        chk1("ser_valid", ser_valid, exp_valid);
        chk1("busy", busy, exp_valid);
        chk1("par_ready", par_ready, exp_pr);
        if (exp_valid) begin
            chk1("serial_out", serial_out, q[0]);
            chk1("ser_first", ser_first, q.size() == FLEN);
            chk1("ser_last", ser_last, q.size() == 1);
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && sr) void'(q.pop_front());
            if (pv && exp_pr) begin
                for (int i = 0; i < COLS; i++) q.push_back(pin[i]);
`ifdef SRD_PARITY_EN
                q.push_back(^pin);
`endif
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk1({nm, "_serial_out"}, serial_out, 1'b0);
        chk1({nm, "_ser_valid"}, ser_valid, 1'b0);
        chk1({nm, "_busy"}, busy, 1'b0);
        chk1({nm, "_ser_first"}, ser_first, 1'b0);
        chk1({nm, "_ser_last"}, ser_last, 1'b0);
        chk1({nm, "_par_ready"}, par_ready, 1'b1);
    endtask

    initial begin
        logic [FLEN-1:0] word;
        int nfirst, nlast, nvalid, npr;

        // Power-on reset
        #12;
        check_reset_outputs("reset");
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Basic frame 8'hA5
        step(1, 8'hA5, 1, 0);
        word = '0; nfirst = 0; nlast = 0;
        for (int k = 0; k < FLEN; k++) begin
            step(0, '0, 1, 0);
            word[k] = s_out;
            if (s_first) begin nfirst++; chkn("basic_first_pos", k, 0); end
            if (s_last)  begin nlast++;  chkn("basic_last_pos", k, FLEN - 1); end
        end
        chkn("basic_bits", int'(word[COLS-1:0]), 32'hA5);
        chkn("basic_nfirst", nfirst, 1);
        chkn("basic_nlast", nlast, 1);
        step(0, '0, 1, 0);
        chk1("basic_idle_valid", s_valid, 1'b0);
        chk1("basic_idle_ready", s_pr, 1'b1);

        // Stall on bit3 of 8'h5A
        step(1, 8'h5A, 1, 0);
        for (int k = 0; k < 3; k++) step(0, '0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, '0, 0, 0);
            chk1("stall_bit3", s_out, 1'b1);
            chk1("stall_valid", s_valid, 1'b1);
            chk1("stall_last", s_last, 1'b0);
        end
        nlast = 0;
        for (int k = 3; k < FLEN; k++) begin
            step(0, '0, 1, 0);
            if (s_last) begin nlast++; chkn("stall_last_pos", k, FLEN - 1); end
        end
        chkn("stall_nlast", nlast, 1);
        step(0, '0, 1, 0);

        // Back-to-back 8'h3C then 8'hFF
        step(1, 8'h3C, 1, 0);
        nvalid = 0; npr = 0; nfirst = 0;
        for (int k = 0; k < 2 * FLEN; k++) begin
            step(k < FLEN, 8'hFF, 1, 0);
            if (s_valid) nvalid++;
            if (k < FLEN && s_pr) begin npr++; chkn("b2b_ready_pos", k, FLEN - 1); end
            if (s_first) begin nfirst++; if (nfirst == 2) chkn("b2b_second_first", k, FLEN); end
        end
        chkn("b2b_nvalid", nvalid, 2 * FLEN);
        chkn("b2b_npr", npr, 1);
        chkn("b2b_nfirst", nfirst, 2);
        step(0, '0, 1, 0);
        chk1("b2b_gap_after", s_valid, 1'b0);

        // Flush on bit4 of 8'hF0, with a competing par_valid
        step(1, 8'hF0, 1, 0);
        for (int k = 0; k < 4; k++) step(0, '0, 1, 0);
        step(1, 8'hAA, 1, 1);
        chk1("flush_bit4", s_out, 1'b1);
        chk1("flush_ready_low", s_pr, 1'b0);
        step(0, '0, 1, 0);
        chk1("flush_valid", s_valid, 1'b0);
        chk1("flush_busy", s_busy, 1'b0);
        chk1("flush_ready", s_pr, 1'b1);

        // Asynchronous reset mid-frame
        step(1, 8'hFF, 1, 0);
        for (int k = 0; k < 3; k++) step(0, '0, 1, 0);
        #1;
        arst_n = 1'b0;
        ser_ready = 1'b0;
        #1;
        check_reset_outputs("areset");
        q.delete();
        #1;
        arst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, '0, 1, 0);
            chk1("areset_no_residual", s_valid, 1'b0);
        end

`ifdef SRD_PARITY_EN
        // Parity: 8'h07 -> parity 1, 8'h03 -> parity 0
        step(1, 8'h07, 1, 0);
        word = '0;
        for (int k = 0; k < FLEN; k++) begin
            step(0, '0, 1, 0);
            word[k] = s_out;
            if (k == FLEN - 1) chk1("par07_last", s_last, 1'b1);
        end
        chkn("par07_frame", int'(word), 32'h107);
        step(1, 8'h03, 1, 0);
        for (int k = 0; k < FLEN; k++) begin
            step(0, '0, 1, 0);
            word[k] = s_out;
        end
        chkn("par03_frame", int'(word), 32'h003);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(1, 0) == 1, COLS'($urandom),
                 $urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
